// File: rtl/spi_bridge_decoder_pkg.sv
// Shared definitions for the PWM SPI bridge: frame layout,
// FSM encodings and register map addresses.
package spi_bridge_decoder_pkg;

  localparam int RW_BIT     = 7;
  localparam int CMD_BITS   = 8;
  localparam int FRAME_BITS = 16;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_CAP  = 3'd3;
  localparam logic [2:0] S_DATA_RD = 3'd4;
  localparam logic [2:0] S_DATA_WR = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [5:0] REG_CTRL   = 6'h00;
  localparam logic [5:0] REG_STATUS = 6'h01;
  localparam logic [5:0] REG_PERIOD = 6'h02;
  localparam logic [5:0] REG_DUTY   = 6'h03;

endpackage

// File: rtl/spi_bridge_decoder_if.sv
// Register-block bus between the SPI bridge (master)
// and the PWM register file (slave).
interface spi_bridge_decoder_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_read;

    modport master (
        output read, write, addr, data_write,
        input  data_read
    );

    modport slave (
        input  read, write, addr, data_write,
        output data_read
    );

endinterface

// File: rtl/spi_bridge_decoder_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin with
// single-cycle rise/fall pulses derived from the synced level.
module spi_bridge_decoder_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_bridge_decoder.sv
// SPI mode-0 slave that decodes 16-bit frames into single-cycle
// register writes or two-cycle register reads with MISO readback.
module spi_bridge_decoder
    import spi_bridge_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_i,
    input  logic cs_n_i,
    input  logic mosi_i,
    output logic miso_o,
    spi_bridge_decoder_if.master bus
);

    localparam int SH_W = (DATA_W > CMD_BITS) ? DATA_W : CMD_BITS;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi;
    logic sclk_lvl_unused, cs_lvl_unused;
    logic mosi_rise_unused, mosi_fall_unused;

    spi_bridge_decoder_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk_i),
        .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_bridge_decoder_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .d_i(cs_n_i),
        .level_o(cs_lvl_unused), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_bridge_decoder_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .d_i(mosi_i),
        .level_o(mosi), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    logic [2:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [SH_W-2:0]   shin_q, shin_d;
    logic [DATA_W-1:0] shout_q, shout_d;
    logic [DATA_W-1:0] dwr_q, dwr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic              miso_q, miso_d;
    logic              write_q, write_d;
    logic              rose_q, rose_d;
    logic              abort_q, abort_d;
    logic              restart_q, restart_d;
    logic              in_read;

    assign in_read = (state_q == S_RD_REQ) || (state_q == S_RD_CAP);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shin_d     = shin_q;
        shout_d    = shout_q;
        dwr_d      = dwr_q;
        addr_d     = addr_q;
        cmd_addr_d = cmd_addr_q;
        miso_d     = 1'b0;
        write_d    = 1'b0;
        rose_d     = rose_q;
        abort_d    = abort_q;
        restart_d  = restart_q;

        if (sclk_rise) shin_d = {shin_q[SH_W-3:0], mosi};

        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d = S_CMD;
                    cnt_d   = 4'd0;
                end
            end
            S_CMD: begin
                if (sclk_rise) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(CMD_BITS - 1)) begin
                        cnt_d      = 4'd0;
                        cmd_addr_d = {shin_q[ADDR_W-2:0], mosi};
                        if (shin_q[RW_BIT-1]) begin
                            state_d = S_DATA_WR;
                        end else begin
                            state_d = S_RD_REQ;
                            addr_d  = {shin_q[ADDR_W-2:0], mosi};
                        end
                    end
                end
            end
            S_RD_REQ: begin
                // The strobe always spans two cycles; pin events are deferred.
                state_d   = S_RD_CAP;
                abort_d   = cs_rise;
                restart_d = cs_fall;
            end
            S_RD_CAP: begin
                shout_d = bus.data_read;
                miso_d  = bus.data_read[DATA_W-1];
                rose_d  = 1'b0;
                cnt_d   = 4'd0;
                abort_d = 1'b0;
                restart_d = 1'b0;
                if (restart_q || cs_fall) begin
                    state_d = S_CMD;
                    miso_d  = 1'b0;
                end else if (abort_q || cs_rise) begin
                    state_d = S_IDLE;
                    miso_d  = 1'b0;
                end else begin
                    state_d = S_DATA_RD;
                end
            end
            S_DATA_RD: begin
                miso_d = miso_q;
                if (sclk_rise) begin
                    rose_d = 1'b1;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'(DATA_W - 1)) begin
                        state_d = S_DONE;
                        miso_d  = 1'b0;
                    end
                end else if (sclk_fall && rose_q) begin
                    shout_d = {shout_q[DATA_W-2:0], 1'b0};
                    miso_d  = shout_q[DATA_W-2];
                end
            end
            S_DATA_WR: begin
                if (sclk_rise) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(DATA_W - 1)) begin
                        dwr_d   = {shin_q[DATA_W-2:0], mosi};
                        addr_d  = cmd_addr_q;
                        write_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (sclk_rise && cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Chip-select edges abort any non-read phase without side effects.
        if (!in_read && (cs_rise || (cs_fall && state_q != S_IDLE))) begin
            state_d = cs_rise ? S_IDLE : S_CMD;
            cnt_d   = 4'd0;
            miso_d  = 1'b0;
            write_d = 1'b0;
            dwr_d   = dwr_q;
            addr_d  = addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            shin_q     <= '0;
            shout_q    <= '0;
            dwr_q      <= '0;
            addr_q     <= '0;
            cmd_addr_q <= '0;
            miso_q     <= 1'b0;
            write_q    <= 1'b0;
            rose_q     <= 1'b0;
            abort_q    <= 1'b0;
            restart_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shin_q     <= shin_d;
            shout_q    <= shout_d;
            dwr_q      <= dwr_d;
            addr_q     <= addr_d;
            cmd_addr_q <= cmd_addr_d;
            miso_q     <= miso_d;
            write_q    <= write_d;
            rose_q     <= rose_d;
            abort_q    <= abort_d;
            restart_q  <= restart_d;
        end
    end

    assign miso_o         = miso_q;
    assign bus.read       = in_read;
    assign bus.write      = write_q;
    assign bus.addr       = addr_q;
    assign bus.data_write = dwr_q;

endmodule

// File: tb/tb_spi_bridge_decoder.sv
// Directed-frame bench: SPI master at clk/16, register model on the bus,
// expected bus events queued and checked by an independent monitor.
`timescale 1ns/1ps
module tb_spi_bridge_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic miso;

    spi_bridge_decoder_if #(.ADDR_W(6), .DATA_W(8)) bus ();

    spi_bridge_decoder #(.SYNC_STAGES(2), .ADDR_W(6), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sclk_i(sclk), .cs_n_i(cs_n),
        .mosi_i(mosi), .miso_o(miso), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] regs [64];
    assign bus.data_read = bus.read ? regs[bus.addr] : 8'h00;
    always @(posedge clk) if (bus.write) regs[bus.addr] <= bus.data_write;

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    typedef struct packed {
        logic       wr;
        logic [5:0] a;
        logic [7:0] d;
    } ev_t;

    ev_t exp_q[$];
    logic [31:0] miso_exp_q[$];
    ev_t mon_e;
    int rd_len = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.read || bus.write)
                chk("rd_wr_excl", 32'(bus.read & bus.write), 32'd0);
            if (bus.write) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none", bus.addr, bus.data_write);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("write_ev", 32'({1'b1, bus.addr, bus.data_write}), 32'({mon_e.wr, mon_e.a, mon_e.d}));
                end
            end
            if (bus.read) begin
                if (rd_len == 0) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_read: got addr %h expected none", bus.addr);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("read_ev", 32'({1'b0, bus.addr}), 32'({mon_e.wr, mon_e.a}));
                    end
                end
                rd_len++;
            end else if (rd_len != 0) begin
                chk("read_len", 32'(rd_len), 32'd2);
                rd_len = 0;
            end
        end
    end

    task automatic spi_frame(input logic [31:0] bits, input int n, input bit raise,
                             output logic [31:0] got);
        got = '0;
        @(negedge clk) cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            got = {got[30:0], miso};
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
        if (raise) begin
            repeat (8) @(negedge clk);
            cs_n = 1'b1;
            mosi = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic full_frame(input logic [31:0] bits, input int n, input string name);
        logic [31:0] got;
        logic [31:0] e;
        spi_frame(bits, n, 1'b1, got);
        e = miso_exp_q.pop_front();
        chk(name, got, e);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_read"}, 32'(bus.read), 32'd0);
        chk({tag, "_write"}, 32'(bus.write), 32'd0);
        chk({tag, "_addr"}, 32'(bus.addr), 32'd0);
        chk({tag, "_dwr"}, 32'(bus.data_write), 32'd0);
        chk({tag, "_miso"}, 32'(miso), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] got;

    initial begin
        for (int i = 0; i < 64; i++) regs[i] = 8'h00;
        regs[6'h0A] = 8'h5A;
        repeat (4) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: plain write
        exp_q.push_back('{1'b1, 6'h02, 8'h01});
        miso_exp_q.push_back(32'h0);
        full_frame(32'h8201, 16, "miso_wr1");

        // 2: read returns 0x5A
        exp_q.push_back('{1'b0, 6'h0A, 8'h00});
        miso_exp_q.push_back(32'h005A);
        full_frame(32'h0A00, 16, "miso_rd1");

        // 3: write aborted after 11 bits, then full write
        spi_frame(32'h42D, 11, 1'b1, got);
        repeat (4) @(negedge clk);
        chk("partial_dwr", 32'(bus.data_write), 32'h01);
        chk("partial_addr", 32'(bus.addr), 32'h0A);
        exp_q.push_back('{1'b1, 6'h00, 8'hFF});
        miso_exp_q.push_back(32'h0);
        full_frame(32'h80FF, 16, "miso_wr3");

        // 4: async reset in the data byte
        spi_frame(32'h8D5, 12, 1'b0, got);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("midrst");
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        exp_q.push_back('{1'b1, 6'h0D, 8'h03});
        miso_exp_q.push_back(32'h0);
        full_frame(32'h8D03, 16, "miso_wr4");

        // 5: 24 clocks, trailing byte ignored
        exp_q.push_back('{1'b1, 6'h0C, 8'h01});
        miso_exp_q.push_back(32'h0);
        full_frame(32'h8C01AA, 24, "miso_wr5");

        // 6: back-to-back write then readback
        exp_q.push_back('{1'b1, 6'h03, 8'h34});
        miso_exp_q.push_back(32'h0);
        full_frame(32'h8334, 16, "miso_wr6");
        exp_q.push_back('{1'b0, 6'h03, 8'h00});
        miso_exp_q.push_back(32'h0034);
        full_frame(32'h0300, 16, "miso_rd6");

        repeat (10) @(negedge clk);
        chk("final_addr", 32'(bus.addr), 32'h03);
        chk("final_dwr", 32'(bus.data_write), 32'h34);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
